hazard_ctrl: RTL

Pipeline hazard and stall controller for the 16-bit five-stage CPU. It consumes the load-use stall request from the forwarding unit, the EX-stage branch/jump redirect, the data-memory busy indication and the WB-stage halt. It drives the hold, bubble, flush and freeze enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It also keeps saturating stall/flush performance counters and a data-memory watchdog.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller state encoding, default sizing
// constants and the control word that bubble/flush consumers load.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2,
        ERROR    = 2'd3
    } hazard_state_t;

    localparam int DEFAULT_MEM_TIMEOUT = 255;
    localparam int DEFAULT_CNT_WIDTH   = 16;

    // All-zero control word: no register write, no memory access, no branch.
    localparam logic [15:0] NOP_CTRL_WORD = 16'h0000;

    // Bits needed for the watchdog to represent MEM_TIMEOUT itself.
    function automatic int wdWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave):
// hazard requests in, pipeline-register enables and perf counters out.
import cpu_pkg::*;

interface hazard_ctrl_if #(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);
    logic                 forwardStall;
    logic                 redirect;
    logic                 memBusy;
    logic                 hlt_WB;
    logic                 stall_IF_ID;
    logic                 bubble_ID_EX;
    logic                 flush_IF_ID;
    logic                 flush_ID_EX;
    logic                 freeze_all;
    logic                 halted;
    logic                 memError;
    logic [CNT_WIDTH-1:0] stallCount;
    logic [CNT_WIDTH-1:0] flushCount;

    modport master (
        output forwardStall, redirect, memBusy, hlt_WB,
        input  stall_IF_ID, bubble_ID_EX, flush_IF_ID, flush_ID_EX,
               freeze_all, halted, memError, stallCount, flushCount
    );

    modport slave (
        input  forwardStall, redirect, memBusy, hlt_WB,
        output stall_IF_ID, bubble_ID_EX, flush_IF_ID, flush_ID_EX,
               freeze_all, halted, memError, stallCount, flushCount
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
import cpu_pkg::*;

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] r_count;

    // Clear wins over increment; increment stops once every bit is set.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: arbitrates halt, data-memory wait,
// branch redirect and load-use stall into pipeline-register enables,
// with saturating perf counters and a data-memory watchdog.
import cpu_pkg::*;

module hazard_ctrl #(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  bus
);
    localparam int WD_WIDTH = wdWidth(MEM_TIMEOUT);

    hazard_state_t        r_state;
    hazard_state_t        w_nextState;
    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_flushIF;
    logic                 w_flushID;
    logic                 w_freeze;
    logic                 w_halted;
    logic                 w_memError;
    logic                 w_stallInc;
    logic                 w_flushInc;
    logic                 w_wdInc;
    logic                 w_wdClear;
    logic [WD_WIDTH-1:0]  w_wdCount;
    logic [CNT_WIDTH-1:0] w_stallCount;
    logic [CNT_WIDTH-1:0] w_flushCount;

    // State register; reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, control enables and counter strobes. A MEM_WAIT cycle in
    // which memory finished is handled exactly like a RUN cycle. Every
    // memory-freeze cycle, including the one that enters MEM_WAIT, counts
    // as a stall cycle.
    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_flushIF   = 1'b0;
        w_flushID   = 1'b0;
        w_freeze    = 1'b0;
        w_halted    = 1'b0;
        w_memError  = 1'b0;
        w_stallInc  = 1'b0;
        w_flushInc  = 1'b0;
        w_wdInc     = 1'b0;
        w_wdClear   = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if ((r_state == MEM_WAIT) && bus.memBusy) begin
                    w_freeze   = 1'b1;
                    w_stallInc = 1'b1;
                    w_wdInc    = 1'b1;
                    if (w_wdCount == WD_WIDTH'(MEM_TIMEOUT)) begin
                        w_nextState = ERROR;
                    end
                end else if (bus.hlt_WB) begin
                    w_wdClear   = 1'b1;
                    w_nextState = HALTED;
                end else if (bus.memBusy) begin
                    w_freeze    = 1'b1;
                    w_stallInc  = 1'b1;
                    w_wdInc     = 1'b1;
                    w_nextState = MEM_WAIT;
                end else begin
                    w_wdClear   = 1'b1;
                    w_nextState = RUN;
                    if (bus.redirect) begin
                        w_flushIF  = 1'b1;
                        w_flushID  = 1'b1;
                        w_flushInc = 1'b1;
                    end else if (bus.forwardStall) begin
                        w_stall    = 1'b1;
                        w_bubble   = 1'b1;
                        w_stallInc = 1'b1;
                    end
                end
            end
            HALTED: begin
                w_freeze = 1'b1;
                w_halted = 1'b1;
            end
            ERROR: begin
                w_freeze   = 1'b1;
                w_halted   = 1'b1;
                w_memError = 1'b1;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stallCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (w_stallInc),
        .o_count (w_stallCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flushCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (w_flushInc),
        .o_count (w_flushCount)
    );

    sat_counter #(.WIDTH(WD_WIDTH)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_wdClear),
        .i_inc   (w_wdInc),
        .o_count (w_wdCount)
    );

    assign bus.stall_IF_ID  = rst_n & w_stall;
    assign bus.bubble_ID_EX = rst_n & w_bubble;
    assign bus.flush_IF_ID  = rst_n & w_flushIF;
    assign bus.flush_ID_EX  = rst_n & w_flushID;
    assign bus.freeze_all   = rst_n & w_freeze;
    assign bus.halted       = rst_n & w_halted;
    assign bus.memError     = rst_n & w_memError;
    assign bus.stallCount   = rst_n ? w_stallCount : '0;
    assign bus.flushCount   = rst_n ? w_flushCount : '0;
endmodule
